// File: rtl/instruction_loader_pkg.sv
// Shared types and frame constants for the instruction loader.
// Frame layout: 2-byte word count, N little-endian words, 4-byte XOR checksum.
package instruction_loader_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN0 = 3'd1,
        LEN1 = 3'd2,
        DATA = 3'd3,
        CSUM = 3'd4,
        FIN  = 3'd5
    } state_t;

    localparam int LEN_BYTES  = 2;
    localparam int WORD_BYTES = 4;
    localparam int CSUM_BYTES = 4;

    // One assembler serves both payload words and the checksum.
    localparam int ASM_BYTES = (WORD_BYTES > CSUM_BYTES) ? WORD_BYTES : CSUM_BYTES;

    localparam int LEN_W = 8 * LEN_BYTES;
    localparam int IDX_W = 13;

    function automatic logic [31:0] word_addr(input logic [31:0] base,
                                              input logic [IDX_W-1:0] idx);
        return base + {{(32-IDX_W-2){1'b0}}, idx, 2'b00};
    endfunction

endpackage

// File: rtl/instruction_loader_byte_word_assembler.sv
// Collects bytes LSB-first into a 32-bit word; word_valid_o flags the byte
// that completes a word, with word_o already holding the full value.
module instruction_loader_byte_word_assembler
    import instruction_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    localparam int CNT_W = $clog2(ASM_BYTES);

    logic [CNT_W-1:0] count_q;
    logic [23:0]      shift_q;

    assign word_o       = {byte_i, shift_q};
    assign word_valid_o = byte_valid_i && (count_q == CNT_W'(ASM_BYTES - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            count_q <= '0;
            shift_q <= '0;
        end else if (byte_valid_i) begin
            count_q <= count_q + CNT_W'(1);
            shift_q <= word_o[31:8];
        end
    end

endmodule

// File: rtl/instruction_loader.sv
// Receives a length/payload/checksum byte frame and writes the payload words
// into instruction memory while holding the core in reset.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int          DEPTH     = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [7:0]  byte_data_i,
    input  logic        byte_valid_i,
    output logic        byte_ready_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        cpu_hold_o,
    output logic        done_o,
    output logic        ok_o
);

    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    state_t             state_q;
    state_t             state_d;
    logic [7:0]         len_lo_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   len_full;
    logic               len_over;
    logic [IDX_W-1:0]   index_q;
    logic [IDX_W-1:0]   index_inc;
    logic               last_word;
    logic [31:0]        xor_q;
    logic               accept;
    logic               asm_valid;
    logic               asm_clear;
    logic [31:0]        asm_word;
    logic               asm_word_valid;

    // The write cycle is a bubble so a new word can never complete on top of it.
    assign byte_ready_o = ((state_q == LEN0) || (state_q == LEN1) ||
                           (state_q == DATA) || (state_q == CSUM)) && !mem_we_o;
    assign accept       = byte_valid_i && byte_ready_o;
    assign asm_valid    = accept && ((state_q == DATA) || (state_q == CSUM));
    assign asm_clear    = (state_q == IDLE) && start_i;

    assign len_full  = {byte_data_i, len_lo_q};
    assign len_over  = 32'(len_full) > DEPTH_U;
    assign index_inc = index_q + IDX_W'(1);
    assign last_word = {{(LEN_W-IDX_W){1'b0}}, index_inc} == len_q;

    instruction_loader_byte_word_assembler u_asm (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (asm_clear),
        .byte_valid_i (asm_valid),
        .byte_i       (byte_data_i),
        .word_o       (asm_word),
        .word_valid_o (asm_word_valid)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        cpu_hold_o = 1'b1;
        done_o     = 1'b0;
        case (state_q)
            IDLE: begin
                cpu_hold_o = 1'b0;
                if (start_i) state_d = LEN0;
            end
            LEN0: if (accept) state_d = LEN1;
            LEN1: begin
                if (accept) begin
                    if (len_over)            state_d = FIN;
                    else if (len_full == '0) state_d = CSUM;
                    else                     state_d = DATA;
                end
            end
            DATA: if (asm_word_valid && last_word) state_d = CSUM;
            CSUM: if (asm_word_valid) state_d = FIN;
            FIN: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            ok_o        <= 1'b0;
            len_lo_q    <= '0;
            len_q       <= '0;
            index_q     <= '0;
            xor_q       <= '0;
        end else begin
            mem_we_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        index_q <= '0;
                        xor_q   <= '0;
                    end
                end
                LEN0: if (accept) len_lo_q <= byte_data_i;
                LEN1: begin
                    if (accept) begin
                        len_q <= len_full;
                        if (len_over) ok_o <= 1'b0;
                    end
                end
                DATA: begin
                    if (asm_word_valid) begin
                        mem_we_o    <= 1'b1;
                        mem_addr_o  <= word_addr(BASE_ADDR, index_q);
                        mem_wdata_o <= asm_word;
                        xor_q       <= xor_q ^ asm_word;
                        index_q     <= index_inc;
                    end
                end
                CSUM: if (asm_word_valid) ok_o <= (asm_word == xor_q);
                default: ;
            endcase
        end
    end

endmodule
